// File: rtl/vec_sync_fifo.sv
// Synchronous FIFO of N-lane 16-bit vectors with registered read port,
// count-derived status flags and sticky overflow/underflow error flags.
module vec_sync_fifo #(
   parameter int unsigned DEPTH = 80,
   parameter int unsigned N     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N*16-1:0]            din,
   input  logic                       wr_en,
   input  logic                       rd_en,
   output logic [N*16-1:0]            dout,
   output logic                       valid_out,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned W  = N * 16;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          rd_acc;
   logic          wr_acc;

   function automatic logic [PW-1:0] ptr_incr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Status depends only on the registered count, never on the requests.
   assign count = cnt;
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);

   // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   always_comb begin
      cnt_next = cnt;
      unique case ({wr_acc, rd_acc})
         2'b10:   cnt_next = cnt + 1'b1;
         2'b01:   cnt_next = cnt - 1'b1;
         default: cnt_next = cnt;
      endcase
   end

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         dout      <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         cnt       <= cnt_next;
         valid_out <= rd_acc;
         if (wr_acc) begin
            wr_ptr <= ptr_incr(wr_ptr);
         end
         if (rd_acc) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= ptr_incr(rd_ptr);
         end
         if (wr_en && full && !rd_acc) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vec_sync_fifo.sv
// Directed self-checking bench for vec_sync_fifo at DEPTH=80, N=64.
module tb_vec_sync_fifo;

   localparam int unsigned DEPTH = 80;
   localparam int unsigned N     = 64;
   localparam int unsigned W     = N * 16;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst;
   logic [W-1:0]  din;
   logic          wr_en;
   logic          rd_en;
   logic [W-1:0]  dout;
   logic          valid_out;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   int checks = 0;
   int errors = 0;

   vec_sync_fifo #(
      .DEPTH(DEPTH),
      .N    (N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .dout     (dout),
      .valid_out(valid_out),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lane 0 carries k; other lanes are offset so lane mixups are visible.
   function automatic logic [W-1:0] mkvec(input int unsigned k);
      logic [W-1:0] v;
      for (int l = 0; l < int'(N); l++) begin
         v[l*16 +: 16] = 16'(k + 32'(l) * 32'd4096);
      end
      return v;
   endfunction

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic fill(input int unsigned base, input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         wr_en = 1'b1; din = mkvec(base + 32'(i));
         step();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = mkvec(1);
      step();
      step();
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      checks++;
      if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full);
      end
      checks++;
      if (valid_out !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || dout !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b ovf=%b unf=%b dout0=%h, want 0/0/0/0",
                  valid_out, overflow, underflow, dout[15:0]);
      end
   endtask

   task automatic test_fill_drain();
      do_reset();
      fill(0, DEPTH);
      checks++;
      if (full !== 1'b1 || count !== CW'(DEPTH)) begin
         errors++;
         $display("FAIL fill_full: full=%b count=%0d, want 1/%0d", full, count, DEPTH);
      end
      rd_en = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         step();
         checks++;
         if (valid_out !== 1'b1 || dout !== mkvec(32'(i))) begin
            errors++;
            $display("FAIL drain_%0d: valid=%b lane0=%h, want 1/%h", i, valid_out, dout[15:0],
                     16'(i));
         end
      end
      rd_en = 1'b0;
      checks++;
      if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL drain_end: empty=%b ovf=%b unf=%b, want 1/0/0", empty, overflow,
                  underflow);
      end
      step();
      checks++;
      if (valid_out !== 1'b0 || dout !== mkvec(DEPTH - 1)) begin
         errors++;
         $display("FAIL drain_hold: valid=%b lane0=%h, want 0/%h", valid_out, dout[15:0],
                  16'(DEPTH - 1));
      end
   endtask

   task automatic test_overflow();
      do_reset();
      fill(0, DEPTH);
      wr_en = 1'b1; din = mkvec(16'hBEEF);
      step();
      wr_en = 1'b0;
      checks++;
      if (full !== 1'b1 || count !== CW'(DEPTH) || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_flag: full=%b count=%0d ovf=%b, want 1/%0d/1", full, count,
                  overflow, DEPTH);
      end
      rd_en = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         step();
         checks++;
         if (valid_out !== 1'b1 || dout !== mkvec(32'(i))) begin
            errors++;
            $display("FAIL overflow_drain_%0d: valid=%b lane0=%h, want 1/%h", i, valid_out,
                     dout[15:0], 16'(i));
         end
      end
      rd_en = 1'b0;
      checks++;
      if (empty !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: empty=%b ovf=%b, want 1/1", empty, overflow);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || count !== '0 || underflow !== 1'b1 || empty !== 1'b1) begin
         errors++;
         $display("FAIL underflow_flag: valid=%b count=%0d unf=%b empty=%b, want 0/0/1/1",
                  valid_out, count, underflow, empty);
      end
      fill(16'h55, 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || dout !== mkvec(16'h55) || underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_recover: valid=%b lane0=%h unf=%b, want 1/0055/1",
                  valid_out, dout[15:0], underflow);
      end
   endtask

   task automatic test_simul_empty();
      do_reset();
      wr_en = 1'b1; rd_en = 1'b1; din = mkvec(7);
      step();
      wr_en = 1'b0;
      checks++;
      if (valid_out !== 1'b0 || count !== CW'(1)) begin
         errors++;
         $display("FAIL simul_empty: valid=%b count=%0d, want 0/1", valid_out, count);
      end
      step();
      rd_en = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || dout !== mkvec(7) || count !== '0) begin
         errors++;
         $display("FAIL simul_empty_read: valid=%b lane0=%h count=%0d, want 1/0007/0",
                  valid_out, dout[15:0], count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fill(0, DEPTH);
      wr_en = 1'b1; rd_en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         din = mkvec(DEPTH + 32'(c));
         step();
         checks++;
         if (valid_out !== 1'b1 || dout !== mkvec(32'(c)) || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL b2b_%0d: valid=%b lane0=%h count=%0d, want 1/%h/%0d", c, valid_out,
                     dout[15:0], count, 16'(c), DEPTH);
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
      checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0 || full !== 1'b1) begin
         errors++;
         $display("FAIL b2b_flags: ovf=%b unf=%b full=%b, want 0/0/1", overflow, underflow,
                  full);
      end
      // Remaining contents must be the last DEPTH writes in order.
      rd_en = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         step();
         checks++;
         if (dout !== mkvec(32'd200 + 32'(i))) begin
            errors++;
            $display("FAIL b2b_tail_%0d: lane0=%h, want %h", i, dout[15:0], 16'(200 + i));
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      fill(16'h100, 40);
      checks++;
      if (count !== CW'(40) || underflow !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: count=%0d unf=%b, want 40/1", count, underflow);
      end
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = mkvec(16'h999);
      step();
      rst = 1'b0; rd_en = 1'b0; din = mkvec(16'h300);
      checks++;
      if (count !== '0 || valid_out !== 1'b0 || underflow !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: count=%0d valid=%b unf=%b ovf=%b, want 0/0/0/0", count,
                  valid_out, underflow, overflow);
      end
      step();
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || dout !== mkvec(16'h300) || empty !== 1'b1) begin
         errors++;
         $display("FAIL mid_post: valid=%b lane0=%h empty=%b, want 1/0300/1", valid_out,
                  dout[15:0], empty);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
      #1;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_simul_empty();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vec_sync_fifo.md
VEC_SYNC_FIFO -- requirements
Module: vec_sync_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 80, giving the number of vector entries stored (DEPTH >= 2; need not be a power of two).
REQ-002 SHALL have parameter N, default 64, giving the number of 16-bit lanes per vector.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port din, input, N*16, write vector.
REQ-006 SHALL have port wr_en, input, 1, write request.
REQ-007 SHALL have port rd_en, input, 1, read (pop) request from the consumer.
REQ-008 SHALL have port dout, output reg, N*16, registered read vector.
REQ-009 SHALL have port valid_out, output reg, 1, high for exactly one cycle per accepted read, qualifying dout.
REQ-010 SHALL have port full, output, 1, high when count == DEPTH.
REQ-011 SHALL have port empty, output, 1, high when count == 0.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1), number of stored entries.
REQ-013 SHALL have port overflow, output reg, 1, sticky error flag for a dropped write.
REQ-014 SHALL have port underflow, output reg, 1, sticky error flag for a rejected read.

Function
REQ-015 SHALL accept a read (rd_acc) when rd_en && !empty.
REQ-016 SHALL accept a write (wr_acc) when wr_en && (!full || rd_acc).
REQ-017 SHALL, on wr_acc, store din at wr_ptr and advance wr_ptr, wrapping from DEPTH-1 to 0.
REQ-018 SHALL, on rd_acc, load dout with the entry at rd_ptr, advance rd_ptr with the same wrap rule, and set valid_out to 1 in the next cycle (1-cycle read latency).
REQ-019 SHALL drive valid_out to 0 in every cycle following a cycle without rd_acc; dout SHALL hold its last value.
REQ-020 SHALL update count by +1 on wr_acc only, by -1 on rd_acc only, and leave it unchanged when both or neither occur.
REQ-021 SHALL, when both are requested while empty, accept the write and reject the read (no fall-through); the new entry SHALL become readable the following cycle.
REQ-022 SHALL, when both are requested while full, accept both; count SHALL stay at DEPTH.
REQ-023 SHALL, on wr_en while full without rd_acc, drop din, leave the contents unchanged, and set overflow to 1.
REQ-024 SHALL, on rd_en while empty, leave the state unchanged, hold valid_out at 0, and set underflow to 1.
REQ-025 SHALL keep overflow and underflow at 1 until rst.
REQ-026 SHALL derive full, empty and count combinationally from the registered count only; they SHALL NOT depend combinationally on wr_en or rd_en.
REQ-027 SHALL preserve strict first-in first-out order across any number of pointer wraps.

Reset
REQ-028 SHALL, while rst is high, set wr_ptr, rd_ptr, count, dout, valid_out, overflow and underflow to 0; empty SHALL be 1 and full 0 in the following cycle.
REQ-029 SHALL give rst priority over wr_en and rd_en in the same cycle; all in-flight data is discarded and storage contents need not be cleared.
REQ-030 SHALL, after rst deasserts, accept a write in the first cycle.

Verification
REQ-031 SHALL cover: DEPTH=80, write vectors with lane0 = 0..79, then 80 consecutive reads -> valid_out high 80 cycles, lane0 = 0..79 in order, empty = 1, overflow = 0.
REQ-032 SHALL cover: fill to 80, then wr_en with lane0 = 0xBEEF, no read -> full = 1, count = 80, overflow = 1, 0xBEEF never read out.
REQ-033 SHALL cover: rd_en on empty after reset -> valid_out = 0, count = 0, underflow = 1; a later write then read returns the written value.
REQ-034 SHALL cover: wr_en and rd_en together on empty (lane0 = 7) -> no valid_out that cycle, count = 1; read next cycle -> dout lane0 = 7 one cycle later.
REQ-035 SHALL cover: fill to 80, then 200 cycles of simultaneous write/read with an incrementing pattern -> count stays 80, output order exact across wraps, no flags set.
REQ-036 SHALL cover: assert rst for one cycle mid-stream with count = 40 -> count = 0, valid_out = 0, flags cleared; the next write/read returns only post-reset data.
